// File: rtl/ats21_alarm_event_queue_if.sv
// rtl/ats21_alarm_event_queue_if.sv - event stream handshake between alarm queue and consumer
// master drives the FIFO head (valid/id), slave returns ready.
interface ats21_alarm_event_queue_if #(
   parameter int ID_WIDTH = 5
);
   logic                evt_valid;
   logic                evt_ready;
   logic [ID_WIDTH-1:0] evt_id;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/ats21_alarm_event_queue.sv
// rtl/ats21_alarm_event_queue.sv - ATS21 alarm edge detect, round-robin pend arbiter, FWFT event FIFO
// Optional drop counter enabled by ATS_EVTQ_DROP_CNT_EN; otherwise drop_cnt is tied to 0.
module ats21_alarm_event_queue #(
   parameter int NUM_ALARMS = 24,
   parameter int FIFO_DEPTH = 8,
   parameter int ID_WIDTH   = $clog2(NUM_ALARMS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_ALARMS-1:0]     alarm_in,
   ats21_alarm_event_queue_if.master evt,
   output logic [NUM_ALARMS-1:0]     pending,
   output logic                      overflow,
   input  logic                      clr_ovf,
   output logic [7:0]                drop_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [NUM_ALARMS-1:0] prev_q, prev_d;
   logic [NUM_ALARMS-1:0] pending_q, pending_d;
   logic [ID_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [ID_WIDTH-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
   logic                  overflow_q, overflow_d;

   logic [NUM_ALARMS-1:0] rise, push_mask, drops;
   logic [ID_WIDTH-1:0]   grant;
   logic                  full, push, pop;

   // First requester found scanning upward from the slot after the last grant.
   function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_ALARMS-1:0] req,
                                                   input logic [ID_WIDTH-1:0]   last);
      logic [ID_WIDTH-1:0] pick;
      logic [ID_WIDTH-1:0] sel;
      logic                found;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_ALARMS; k++) begin
         sel = ID_WIDTH'((int'(last) + k) % NUM_ALARMS);
         if (!found && req[sel]) begin
            pick  = sel;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      rise      = alarm_in & ~prev_q;
      full      = (count_q == CNT_W'(FIFO_DEPTH));
      grant     = rr_pick(pending_q, last_grant_q);
      push      = (pending_q != '0) && !full;
      pop       = (count_q != '0) && evt.evt_ready;
      push_mask = push ? (NUM_ALARMS'(1) << grant) : '0;
      // A rise on a bit being pushed this edge re-pends it instead of dropping.
      drops     = rise & pending_q & ~push_mask;

      prev_d    = alarm_in;
      pending_d = (pending_q & ~push_mask) | rise;
      mem_d     = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = grant;
      end
      wr_ptr_d     = wr_ptr_q + PTR_W'(push);
      rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
      count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
      last_grant_d = push ? grant : last_grant_q;
      overflow_d   = (overflow_q & ~clr_ovf) | (|drops);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q       <= '0;
         pending_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= ID_WIDTH'(NUM_ALARMS - 1);
         overflow_q   <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         pending_q    <= pending_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
         overflow_q   <= overflow_d;
      end
   end

`ifdef ATS_EVTQ_DROP_CNT_EN
   localparam int DC_W = $clog2(NUM_ALARMS + 1);

   logic [DC_W-1:0] n_drops;
   logic [8:0]      cnt_sum;
   logic [7:0]      drop_cnt_q, drop_cnt_d;

   always_comb begin
      n_drops = '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         n_drops = n_drops + DC_W'(drops[k]);
      end
      cnt_sum    = (clr_ovf ? 9'd0 : {1'b0, drop_cnt_q}) + 9'(n_drops);
      drop_cnt_d = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'd0;
`endif

   assign evt.evt_valid = (count_q != '0);
   assign evt.evt_id    = mem_q[rd_ptr_q];
   assign pending       = pending_q;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_ats21_alarm_event_queue.sv
// tb/tb_ats21_alarm_event_queue.sv - scoreboard bench for ats21_alarm_event_queue
// Delivered IDs are checked in order against a queue filled as alarms are driven.
module tb_ats21_alarm_event_queue;
   logic        clk;
   logic        reset;
   logic [23:0] alarm_in;
   logic [23:0] pending;
   logic        overflow;
   logic        clr_ovf;
   logic [7:0]  drop_cnt;

   int total;
   int bad;
   logic [4:0] sb[$];

`ifdef ATS_EVTQ_DROP_CNT_EN
   localparam logic [7:0] EXP_DROP1 = 8'd1;
`else
   localparam logic [7:0] EXP_DROP1 = 8'd0;
`endif

   ats21_alarm_event_queue_if #(.ID_WIDTH(5)) evt_if ();

   ats21_alarm_event_queue #(
      .NUM_ALARMS(24),
      .FIFO_DEPTH(8),
      .ID_WIDTH(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .alarm_in(alarm_in),
      .evt(evt_if),
      .pending(pending),
      .overflow(overflow),
      .clr_ovf(clr_ovf),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Scoreboard monitor: each accepted event must match the oldest expected ID.
   always @(negedge clk) begin
      if (reset && evt_if.evt_valid && evt_if.evt_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got id=%0d, required no event", evt_if.evt_id);
         end else begin
            logic [4:0] exp_id;
            exp_id = sb.pop_front();
            if (evt_if.evt_id !== exp_id) begin
               bad++;
               $display("FAIL sb_id: got id=%0d, required %0d", evt_if.evt_id, exp_id);
            end
         end
      end
   end

   task automatic do_reset();
      reset            = 1'b0;
      alarm_in         = '0;
      evt_if.evt_ready = 1'b0;
      clr_ovf          = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic pulse_seq(input int first, input int n);
      logic [23:0] a;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         a = '0;
         a[first+i] = 1'b1;
         if (i > 0) a[first+i-1] = 1'b1;
         alarm_in = a;
      end
      @(posedge clk); #1 alarm_in = '0;
   endtask

   task automatic pulse_one(input int idx, input bit with_clr);
      @(posedge clk); #1;
      alarm_in = 24'd1 << idx;
      clr_ovf  = with_clr;
      @(posedge clk); #1 clr_ovf = 1'b0;
      @(posedge clk); #1 alarm_in = '0;
   endtask

   task automatic test_reset();
      reset            = 1'b0;
      alarm_in         = '0;
      evt_if.evt_ready = 1'b0;
      clr_ovf          = 1'b0;
      @(negedge clk);
      total++;
      if (evt_if.evt_valid !== 1'b0 || evt_if.evt_id !== 5'd0) begin
         bad++;
         $display("FAIL reset_head: valid=%b id=%0d, required 0/0", evt_if.evt_valid, evt_if.evt_id);
      end
      total++;
      if (pending !== 24'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_state: pending=%h ovf=%b drop=%0d, required 0/0/0", pending, overflow, drop_cnt);
      end
      @(posedge clk); #1 reset = 1'b1;
   endtask

   task automatic test_single_pulse();
      do_reset();
      evt_if.evt_ready = 1'b1;
      sb.push_back(5'd5);
      @(posedge clk); #1 alarm_in = 24'd1 << 5;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (pending !== (24'd1 << 5) || evt_if.evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_pend: pending=%h valid=%b, required 000020/0", pending, evt_if.evt_valid);
      end
      @(posedge clk); #1 alarm_in = '0;
      @(negedge clk);
      total++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 5'd5 || pending !== 24'd0) begin
         bad++;
         $display("FAIL single_head: valid=%b id=%0d pending=%h, required 1/5/0", evt_if.evt_valid, evt_if.evt_id, pending);
      end
      @(negedge clk);
      total++;
      if (evt_if.evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_onecycle: valid=%b, required 0", evt_if.evt_valid);
      end
      repeat (4) @(negedge clk);
      total++;
      if (evt_if.evt_valid !== 1'b0 || sb.size() != 0) begin
         bad++;
         $display("FAIL single_noextra: valid=%b left=%0d, required 0/0", evt_if.evt_valid, sb.size());
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] exp_ids[3];
      exp_ids = '{5'd3, 5'd7, 5'd20};
      do_reset();
      evt_if.evt_ready = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(exp_ids[i]);
      @(posedge clk); #1 alarm_in = (24'd1 << 3) | (24'd1 << 7) | (24'd1 << 20);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (pending !== 24'h100088) begin
         bad++;
         $display("FAIL simul_pend: pending=%h, required 100088", pending);
      end
      @(posedge clk); #1 alarm_in = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== exp_ids[i]) begin
            bad++;
            $display("FAIL simul_seq%0d: valid=%b id=%0d, required 1/%0d", i, evt_if.evt_valid, evt_if.evt_id, exp_ids[i]);
         end
         if (i < 2) @(posedge clk);
      end
      total++;
      if (pending !== 24'd0) begin
         bad++;
         $display("FAIL simul_pend_clear: pending=%h, required 0", pending);
      end
      for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL simul_drain: left=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 10; i++) sb.push_back(5'(i));
      pulse_seq(0, 10);
      repeat (4) @(posedge clk);
      @(negedge clk);
      total++;
      if (pending !== 24'h000300) begin
         bad++;
         $display("FAIL bp_pending: pending=%h, required 000300", pending);
      end
      total++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 5'd0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL bp_head: valid=%b id=%0d ovf=%b, required 1/0/0", evt_if.evt_valid, evt_if.evt_id, overflow);
      end
      @(posedge clk); #1 evt_if.evt_ready = 1'b1;
      for (int c = 0; c < 60 && sb.size() != 0; c++) @(posedge clk);
      @(negedge clk);
      total++;
      if (sb.size() != 0 || pending !== 24'd0 || overflow !== 1'b0 || evt_if.evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_drain: left=%0d pending=%h ovf=%b valid=%b, required 0/0/0/0", sb.size(), pending, overflow, evt_if.evt_valid);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) sb.push_back(5'(i));
      sb.push_back(5'd9);
      pulse_seq(0, 8);
      repeat (3) @(posedge clk);
      pulse_one(9, 1'b0);
      @(negedge clk);
      total++;
      if (pending !== (24'd1 << 9) || overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_first: pending=%h ovf=%b, required 000200/0", pending, overflow);
      end
      pulse_one(9, 1'b0);
      @(negedge clk);
      total++;
      if (overflow !== 1'b1 || drop_cnt !== EXP_DROP1) begin
         bad++;
         $display("FAIL ovf_drop: ovf=%b drop=%0d, required 1/%0d", overflow, drop_cnt, EXP_DROP1);
      end
      pulse_one(9, 1'b1);
      @(negedge clk);
      total++;
      if (overflow !== 1'b1 || drop_cnt !== EXP_DROP1) begin
         bad++;
         $display("FAIL ovf_clr_vs_drop: ovf=%b drop=%0d, required 1/%0d", overflow, drop_cnt, EXP_DROP1);
      end
      @(posedge clk); #1 clr_ovf = 1'b1;
      @(posedge clk); #1 clr_ovf = 1'b0;
      @(negedge clk);
      total++;
      if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
         bad++;
         $display("FAIL ovf_clear: ovf=%b drop=%0d, required 0/0", overflow, drop_cnt);
      end
      evt_if.evt_ready = 1'b1;
      for (int c = 0; c < 60 && sb.size() != 0; c++) @(posedge clk);
      @(negedge clk);
      total++;
      if (sb.size() != 0 || pending !== 24'd0) begin
         bad++;
         $display("FAIL ovf_drain: left=%0d pending=%h, required 0/0", sb.size(), pending);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_seq(10, 5);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 5'd10) begin
         bad++;
         $display("FAIL mid_queued: valid=%b id=%0d, required 1/10", evt_if.evt_valid, evt_if.evt_id);
      end
      @(posedge clk); #1;
      reset    = 1'b0;
      alarm_in = 24'd1 << 2;
      #1;
      total++;
      if (evt_if.evt_valid !== 1'b0 || pending !== 24'd0) begin
         bad++;
         $display("FAIL mid_flush: valid=%b pending=%h, required 0/0", evt_if.evt_valid, pending);
      end
      sb.delete();
      sb.push_back(5'd2);
      evt_if.evt_ready = 1'b1;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (pending !== (24'd1 << 2)) begin
         bad++;
         $display("FAIL mid_rise_at_release: pending=%h, required 000004", pending);
      end
      @(posedge clk); #1 alarm_in = '0;
      for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clk);
      repeat (2) @(negedge clk);
      total++;
      if (sb.size() != 0 || evt_if.evt_valid !== 1'b0 || pending !== 24'd0) begin
         bad++;
         $display("FAIL mid_post: left=%0d valid=%b pending=%h, required 0/0/0", sb.size(), evt_if.evt_valid, pending);
      end
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      reset            = 1'b0;
      alarm_in         = '0;
      clr_ovf          = 1'b0;
      evt_if.evt_ready = 1'b0;
      test_reset();
      test_single_pulse();
      test_simultaneous();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
